// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive datapath.
//   state_e    : phase-sequencer states
//   CTRL_*     : the four TMDS control tokens recognised by the word detectors
//   PHASE_W    : width of the bit-slip phase select
package tmds_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_MEASURE,
    ST_ADVANCE,
    ST_LOCKED
  } state_e;

  // Control tokens for {C1,C0} = 00, 01, 10, 11.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic is_ctrl_code(input logic [9:0] word);
    return (word == CTRL_00) || (word == CTRL_01) ||
           (word == CTRL_10) || (word == CTRL_11);
  endfunction

endpackage

// File: rtl/tmds_window_counter.sv
// Measurement window and control-word hit counters.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : zero the window and both hit counters
//   enable      : count this cycle
//   ctrl_hit    : per-channel control-word hit flags
//   window_end  : this enabled cycle is the last of the window
//   pass        : window (including this cycle) met the hit criteria;
//                 meaningful when window_end is high
module tmds_window_counter #(
  parameter int unsigned WINDOW_BITS = 16,
  parameter int unsigned MIN_HITS    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [2:0] ctrl_hit,
  output logic       window_end,
  output logic       pass
);

  logic [WINDOW_BITS-1:0] win_q, win_d;
  logic [WINDOW_BITS:0]   hits0_q, hits0_d;
  logic [WINDOW_BITS:0]   hits_all_q, hits_all_d;
  logic [WINDOW_BITS:0]   hits0_inc, hits_all_inc;

  always_comb begin
    hits0_inc    = hits0_q + {{WINDOW_BITS{1'b0}}, ctrl_hit[0]};
    hits_all_inc = hits_all_q + {{WINDOW_BITS{1'b0}}, &ctrl_hit};

    window_end = enable && (win_q == '1);
    // The final cycle's hit is folded in via the *_inc values.
    pass = (32'(hits0_inc) >= MIN_HITS) && (hits_all_inc != '0);

    win_d      = win_q;
    hits0_d    = hits0_q;
    hits_all_d = hits_all_q;
    // Restarting on window_end gives back-to-back windows.
    if (clear || window_end) begin
      win_d      = '0;
      hits0_d    = '0;
      hits_all_d = '0;
    end else if (enable) begin
      win_d      = win_q + 1'b1;
      hits0_d    = hits0_inc;
      hits_all_d = hits_all_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q      <= '0;
      hits0_q    <= '0;
      hits_all_q <= '0;
    end else begin
      win_q      <= win_d;
      hits0_q    <= hits0_d;
      hits_all_q <= hits_all_d;
    end
  end

endmodule

// File: rtl/tmds_phase_ctrl.sv
// TMDS receive phase sequencer: sweeps the bit-slip phase, qualifies each
// phase over a hit-counting window, locks on the first passing phase and
// re-scans after MAX_MISS consecutive failed windows.
//   hdmi_clk    : pixel clock (only clock)
//   reset       : synchronous active-low reset
//   pll_locked  : asynchronous PLL lock, synchronised internally
//   ctrl_hit    : per-channel control-word hit flags
//   phase       : selected phase 0..PHASES-1
//   valid       : link aligned (LOCKED)
//   scanning    : SETTLE or MEASURE
//   relock      : one-cycle strobe on LOCKED -> ADVANCE
//   sweep_fail  : one-cycle strobe when a full sweep of all phases failed
//   sweep_count : failed sweeps, saturating at 255
module tmds_phase_ctrl
  import tmds_pkg::*;
#(
  parameter int unsigned PHASES      = 5,
  parameter int unsigned WINDOW_BITS = 16,
  parameter int unsigned MIN_HITS    = 64,
  parameter int unsigned SETTLE      = 16,
  parameter int unsigned MAX_MISS    = 2
) (
  input  logic               hdmi_clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic [2:0]         ctrl_hit,
  output logic [PHASE_W-1:0] phase,
  output logic               valid,
  output logic               scanning,
  output logic               relock,
  output logic               sweep_fail,
  output logic [7:0]         sweep_count
);

  localparam int unsigned SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned FAIL_W   = $clog2(PHASES + 1);
  localparam int unsigned MISS_W   = $clog2(MAX_MISS + 1);

  state_e               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 lock_s_q, lock_s_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 valid_q, valid_d;
  logic                 scanning_q, scanning_d;
  logic                 relock_q, relock_d;
  logic                 sweep_fail_q, sweep_fail_d;
  logic [7:0]           sweep_count_q, sweep_count_d;

  logic win_clear, win_enable, window_end, win_pass;

  tmds_window_counter #(
    .WINDOW_BITS (WINDOW_BITS),
    .MIN_HITS    (MIN_HITS)
  ) u_window (
    .clk        (hdmi_clk),
    .rst_n      (reset),
    .clear      (win_clear),
    .enable     (win_enable),
    .ctrl_hit   (ctrl_hit),
    .window_end (window_end),
    .pass       (win_pass)
  );

  always_comb begin
    sync1_d       = pll_locked;
    lock_s_d      = sync1_q;
    state_d       = state_q;
    settle_d      = settle_q;
    fail_cnt_d    = fail_cnt_q;
    miss_d        = miss_q;
    phase_d       = phase_q;
    sweep_count_d = sweep_count_q;
    relock_d      = 1'b0;
    sweep_fail_d  = 1'b0;

    win_enable = lock_s_q && ((state_q == ST_MEASURE) || (state_q == ST_LOCKED));
    // Counters sit cleared outside MEASURE/LOCKED, so every measurement
    // starts from zero on the first MEASURE cycle.
    win_clear  = (state_q != ST_MEASURE) && (state_q != ST_LOCKED);

    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_W'(SETTLE - 1);
        end
      end

      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_MEASURE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      ST_MEASURE: begin
        if (window_end) begin
          if (win_pass) begin
            state_d    = ST_LOCKED;
            miss_d     = '0;
            fail_cnt_d = '0;
          end else begin
            state_d = ST_ADVANCE;
          end
        end
      end

      ST_ADVANCE: begin
        phase_d = (phase_q == PHASE_W'(PHASES - 1)) ? '0 : phase_q + 1'b1;
        if (fail_cnt_q == FAIL_W'(PHASES - 1)) begin
          fail_cnt_d   = '0;
          sweep_fail_d = 1'b1;
          if (sweep_count_q != '1) begin
            sweep_count_d = sweep_count_q + 1'b1;
          end
        end else begin
          fail_cnt_d = fail_cnt_q + 1'b1;
        end
        state_d  = ST_SETTLE;
        settle_d = SETTLE_W'(SETTLE - 1);
      end

      ST_LOCKED: begin
        if (window_end) begin
          if (win_pass) begin
            miss_d = '0;
          end else if (miss_q == MISS_W'(MAX_MISS - 1)) begin
            relock_d   = 1'b1;
            state_d    = ST_ADVANCE;
            miss_d     = '0;
            fail_cnt_d = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      end

      default: state_d = ST_WAIT_LOCK;
    endcase

    // Loss of lock overrides everything above; phase and sweep
    // bookkeeping are held so the re-scan resumes where it was.
    if (!lock_s_q) begin
      state_d       = ST_WAIT_LOCK;
      phase_d       = phase_q;
      fail_cnt_d    = fail_cnt_q;
      sweep_count_d = sweep_count_q;
      miss_d        = '0;
      relock_d      = 1'b0;
      sweep_fail_d  = 1'b0;
    end

    valid_d    = (state_d == ST_LOCKED);
    scanning_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
  end

  always_ff @(posedge hdmi_clk) begin
    if (!reset) begin
      state_q       <= ST_WAIT_LOCK;
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      settle_q      <= '0;
      fail_cnt_q    <= '0;
      miss_q        <= '0;
      phase_q       <= '0;
      valid_q       <= 1'b0;
      scanning_q    <= 1'b0;
      relock_q      <= 1'b0;
      sweep_fail_q  <= 1'b0;
      sweep_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      lock_s_q      <= lock_s_d;
      settle_q      <= settle_d;
      fail_cnt_q    <= fail_cnt_d;
      miss_q        <= miss_d;
      phase_q       <= phase_d;
      valid_q       <= valid_d;
      scanning_q    <= scanning_d;
      relock_q      <= relock_d;
      sweep_fail_q  <= sweep_fail_d;
      sweep_count_q <= sweep_count_d;
    end
  end

  assign phase       = phase_q;
  assign valid       = valid_q;
  assign scanning    = scanning_q;
  assign relock      = relock_q;
  assign sweep_fail  = sweep_fail_q;
  assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_tmds_phase_ctrl.sv
// Self-checking bench for tmds_phase_ctrl (PHASES=5, WINDOW_BITS=6,
// MIN_HITS=8, SETTLE=4, MAX_MISS=2). Expected valid-rise, relock and
// sweep_fail events are queued with their cycle, phase and sweep_count,
// and checked as the DUT produces them.
module tb_tmds_phase_ctrl;

  localparam int EV_VALID = 0;
  localparam int EV_RELOCK = 1;
  localparam int EV_SWEEP = 2;

  typedef struct {
    int kind;
    int at;
    int ph;
    int sc;
  } ev_t;

  logic       hdmi_clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic [2:0] ctrl_hit;
  logic [2:0] phase;
  logic       valid, scanning, relock, sweep_fail;
  logic [7:0] sweep_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  sb[$];
  ev_t  exp_e;
  logic valid_prev = 1'b0;
  logic seen;

  // Stimulus mode: 0 = constant pattern, 1 = 3'b111 only at phase tgt.
  int         mode = 0;
  logic [2:0] pat = 3'b000;
  logic [2:0] tgt = 3'd0;

  tmds_phase_ctrl #(
    .PHASES      (5),
    .WINDOW_BITS (6),
    .MIN_HITS    (8),
    .SETTLE      (4),
    .MAX_MISS    (2)
  ) dut (
    .hdmi_clk    (hdmi_clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .ctrl_hit    (ctrl_hit),
    .phase       (phase),
    .valid       (valid),
    .scanning    (scanning),
    .relock      (relock),
    .sweep_fail  (sweep_fail),
    .sweep_count (sweep_count)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  always @(posedge hdmi_clk) cyc <= cyc + 1;

  // Scoreboard: compare each observed event against the queue head.
  always @(negedge hdmi_clk) begin
    if (!reset) begin
      valid_prev = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        seen = (k == EV_VALID) ? (valid && !valid_prev) :
               (k == EV_RELOCK) ? relock : sweep_fail;
        if (seen) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d at cyc=%0d phase=%0d sc=%0d, required none",
                     k, cyc, phase, sweep_count);
          end else begin
            exp_e = sb.pop_front();
            if (exp_e.kind != k || exp_e.at != cyc ||
                exp_e.ph != int'(phase) || exp_e.sc != int'(sweep_count)) begin
              errors++;
              $display("FAIL event: got kind=%0d cyc=%0d phase=%0d sc=%0d, required kind=%0d cyc=%0d phase=%0d sc=%0d",
                       k, cyc, phase, sweep_count, exp_e.kind, exp_e.at, exp_e.ph, exp_e.sc);
            end
          end
        end
      end
      valid_prev = valid;
    end
  end

  task automatic tick();
    @(posedge hdmi_clk);
    #1;
    if (mode == 1) ctrl_hit = (phase == tgt) ? 3'b111 : 3'b000;
    else           ctrl_hit = pat;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    mode = 0; pat = 3'b000;
    do_reset();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_phase: got %0d, required 0", phase); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", valid); end
    checks++; if (scanning !== 1'b0) begin errors++; $display("FAIL rst_scanning: got %b, required 0", scanning); end
    checks++; if (relock !== 1'b0) begin errors++; $display("FAIL rst_relock: got %b, required 0", relock); end
    checks++; if (sweep_fail !== 1'b0) begin errors++; $display("FAIL rst_sweep_fail: got %b, required 0", sweep_fail); end
    checks++; if (sweep_count !== 8'd0) begin errors++; $display("FAIL rst_sweep_count: got %0d, required 0", sweep_count); end
  endtask

  task automatic test_const_lock();
    int n;
    mode = 0; pat = 3'b111; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    sb.push_back('{EV_VALID, n + 71, 0, 0});
    while (cyc < n + 2) tick();
    checks++; if (scanning !== 1'b0) begin errors++; $display("FAIL const_scan_pre: got %b, required 0", scanning); end
    tick();
    checks++; if (scanning !== 1'b1) begin errors++; $display("FAIL const_scan_on: got %b, required 1", scanning); end
    while (cyc < n + 72) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL const_lock_timeout: got %0d pending, required 0", sb.size()); end
    checks++; if (valid !== 1'b1 || phase !== 3'd0) begin errors++; $display("FAIL const_locked: got valid=%b phase=%0d, required 1/0", valid, phase); end
    checks++; if (scanning !== 1'b0) begin errors++; $display("FAIL const_scan_off: got %b, required 0", scanning); end
    // Stay locked for a few more windows; any relock would be unexpected.
    repeat (200) tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL const_hold: got %b, required 1", valid); end
  endtask

  task automatic test_scan_to_phase3();
    int n;
    mode = 1; tgt = 3'd3; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    sb.push_back('{EV_VALID, n + 278, 3, 0});
    while (cyc < n + 73) tick();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL scan_phase1: got %0d, required 1", phase); end
    while (cyc < n + 279) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scan_lock_timeout: got %0d pending, required 0", sb.size()); end
    checks++; if (phase !== 3'd3 || valid !== 1'b1) begin errors++; $display("FAIL scan_locked: got phase=%0d valid=%b, required 3/1", phase, valid); end
  endtask

  task automatic test_sweep_fail();
    int n;
    mode = 0; pat = 3'b000; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    for (int j = 0; j < 3; j++) sb.push_back('{EV_SWEEP, n + 348 + 345 * j, 0, j + 1});
    while (cyc < n + 347) tick();
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL sweep_last_phase: got %0d, required 4", phase); end
    while (cyc < n + 1040) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sweep_timeout: got %0d pending, required 0", sb.size()); end
    checks++; if (sweep_count !== 8'd3) begin errors++; $display("FAIL sweep_count: got %0d, required 3", sweep_count); end
  endtask

  task automatic test_relock();
    int n;
    mode = 1; tgt = 3'd2; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    sb.push_back('{EV_VALID, n + 209, 2, 0});
    sb.push_back('{EV_RELOCK, n + 337, 2, 0});
    while (cyc < n + 209) tick();
    mode = 0; pat = 3'b000;
    while (cyc < n + 336) tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL relock_still_valid: got %b, required 1", valid); end
    tick();
    checks++; if (valid !== 1'b0 || relock !== 1'b1) begin errors++; $display("FAIL relock_strobe: got valid=%b relock=%b, required 0/1", valid, relock); end
    tick();
    checks++; if (phase !== 3'd3 || relock !== 1'b0) begin errors++; $display("FAIL relock_phase: got phase=%0d relock=%b, required 3/0", phase, relock); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL relock_timeout: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_pll_drop();
    int n;
    mode = 1; tgt = 3'd2; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    sb.push_back('{EV_VALID, n + 209, 2, 0});
    sb.push_back('{EV_VALID, n + 281, 2, 0});
    while (cyc < n + 209) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL drop_sync_latency: got %b, required 1", valid); end
    tick();
    checks++; if (valid !== 1'b0 || phase !== 3'd2 || scanning !== 1'b0) begin errors++; $display("FAIL drop_wait_lock: got valid=%b phase=%0d scan=%b, required 0/2/0", valid, phase, scanning); end
    tick();
    checks++; if (scanning !== 1'b1 || phase !== 3'd2) begin errors++; $display("FAIL drop_resume: got scan=%b phase=%0d, required 1/2", scanning, phase); end
    while (cyc < n + 282) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drop_relock_timeout: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_measure();
    int n;
    int m;
    mode = 0; pat = 3'b000; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    sb.push_back('{EV_SWEEP, n + 348, 0, 1});
    while (cyc < n + 430) tick();
    checks++; if (phase !== 3'd1 || scanning !== 1'b1 || sweep_count !== 8'd1) begin errors++; $display("FAIL mid_pre: got phase=%0d scan=%b sc=%0d, required 1/1/1", phase, scanning, sweep_count); end
    reset = 1'b0;
    pat = 3'b111;
    tick();
    checks++; if (phase !== 3'd0 || valid !== 1'b0 || scanning !== 1'b0 || relock !== 1'b0 || sweep_fail !== 1'b0 || sweep_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got phase=%0d valid=%b scan=%b relock=%b sf=%b sc=%0d, required all 0",
               phase, valid, scanning, relock, sweep_fail, sweep_count);
    end
    reset = 1'b1;
    m = cyc;
    sb.push_back('{EV_VALID, m + 71, 0, 0});
    while (cyc < m + 72) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_restart_timeout: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_ch0_only();
    int n;
    mode = 0; pat = 3'b001; pll_locked = 1'b1;
    do_reset();
    reset = 1'b1;
    n = cyc;
    sb.push_back('{EV_SWEEP, n + 348, 0, 1});
    sb.push_back('{EV_SWEEP, n + 693, 0, 2});
    while (cyc < n + 700) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ch0_timeout: got %0d pending, required 0", sb.size()); end
    checks++; if (valid !== 1'b0 || sweep_count !== 8'd2) begin errors++; $display("FAIL ch0_state: got valid=%b sc=%0d, required 0/2", valid, sweep_count); end
  endtask

  initial begin
    reset = 1'b0;
    pll_locked = 1'b0;
    ctrl_hit = 3'b000;
    test_reset();
    test_const_lock();
    test_scan_to_phase3();
    test_sweep_fail();
    test_relock();
    test_pll_drop();
    test_reset_mid_measure();
    test_ch0_only();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
